// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a shared fixed-latency memory
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_stall,
  input  logic                  d_req,
  input  logic                  d_wen,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_stall,
  output logic                  mem_en,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LAT_M1     = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t                r_state;
  logic [3:0]            r_wait_cnt;
  logic [3:0]            r_starve_cnt;
  logic                  r_grant_d;
  logic                  r_if_ack;
  logic                  r_d_ack;
  logic                  r_mem_en;
  logic                  r_mem_wen;
  logic                  r_busy;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  w_grant_d;

  // Data wins unless it is idle or fetch has waited out the starvation limit.
  assign w_grant_d = d_req & ~(if_req & (r_starve_cnt == STARVE_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_starve_cnt <= '0;
      r_grant_d    <= 1'b0;
      r_if_ack     <= 1'b0;
      r_d_ack      <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_busy       <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (if_req | d_req) begin
            r_grant_d <= w_grant_d;
            r_mem_en  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_ISSUE;
            if (w_grant_d) begin
              r_mem_addr  <= d_addr;
              r_mem_wen   <= d_wen;
              r_mem_wdata <= d_wdata;
              if (!if_req)
                r_starve_cnt <= '0;
              else if (r_starve_cnt != STARVE_MAX)
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end else begin
              r_mem_addr   <= if_addr;
              r_mem_wen    <= 1'b0;
              r_mem_wdata  <= '0;
              r_starve_cnt <= '0;
            end
          end
        end
        S_ISSUE: begin
          r_mem_en <= 1'b0;
          if (MEM_LATENCY == 1) begin
            r_state  <= S_RESP;
            r_if_ack <= ~r_grant_d;
            r_d_ack  <= r_grant_d;
          end else begin
            r_state    <= S_WAIT;
            r_wait_cnt <= LAT_M1;
          end
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt - 4'd1;
          if (r_wait_cnt == 4'd1) begin
            r_state  <= S_RESP;
            r_if_ack <= ~r_grant_d;
            r_d_ack  <= r_grant_d;
          end
        end
        S_RESP: begin
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;
  assign if_rdata  = r_if_ack ? mem_rdata : '0;
  assign d_rdata   = r_d_ack ? mem_rdata : '0;
  // Gated by reset so the hazard logic sees no stall while the arbiter is held.
  assign if_stall  = reset & if_req & ~r_if_ack;
  assign d_stall   = reset & d_req & ~r_d_ack;
  assign mem_en    = r_mem_en;
  assign mem_wen   = r_mem_wen;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed table and sequence checks for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_wen;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_ack, if_stall, d_ack, d_stall, mem_en, mem_wen, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        if1_req, if1_ack, if1_stall, d1_ack, d1_stall, mem1_en, mem1_wen, busy1;
  logic [31:0] if1_addr, if1_rdata, d1_rdata, mem1_addr, mem1_wdata, mem1_rdata;

  logic [31:0] r_p0, r_p1, r_q0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if1_req), .if_addr(if1_addr), .if_ack(if1_ack), .if_rdata(if1_rdata), .if_stall(if1_stall),
    .d_req(1'b0), .d_wen(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_ack(d1_ack), .d_rdata(d1_rdata), .d_stall(d1_stall),
    .mem_en(mem1_en), .mem_wen(mem1_wen), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata),
    .mem_rdata(mem1_rdata), .busy(busy1)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // Memory models: data appears MEM_LATENCY cycles after the mem_en cycle.
  always @(posedge clk) begin
    r_p0 <= mem_en ? memf(mem_addr) : 32'h0;
    r_p1 <= r_p0;
    r_q0 <= mem1_en ? memf(mem1_addr) : 32'h0;
  end
  assign mem_rdata  = r_p1;
  assign mem1_rdata = r_q0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {32'h0, if_ack, if_stall, d_ack, d_stall, mem_en, mem_wen, busy}, 64'h0);
    check({name, "_data"}, {if_rdata | d_rdata, mem_addr | mem_wdata}, 64'h0);
  endtask

  typedef struct {
    logic        ifr;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic        exp_d;
    logic [31:0] exp_addr;
    logic        exp_wen;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vt[6];
  logic exp_seq[6];

  initial begin
    int acks1, last1, viol1;
    bit got, prev_en;

    vt[0] = '{1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 32'h0,         1'b0, 32'h0000_0010, 1'b0, 32'h0};
    vt[1] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0200, 32'hDEADBEEF, 1'b1, 32'h0000_0200, 1'b1, 32'hDEADBEEF};
    vt[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0104, 32'h0,  1'b1, 32'h0000_0104, 1'b0, 32'h0};
    vt[3] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0,         1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0};
    vt[4] = '{1'b1, 32'h0000_0020, 1'b1, 1'b1, 32'h0000_0208, 32'h12345678, 1'b1, 32'h0000_0208, 1'b1, 32'h12345678};
    vt[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 32'h0,  1'b1, 32'h0000_0000, 1'b0, 32'h0};
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    if1_req = 1'b0; if1_addr = 32'h0;
    #3 check_all_zero("reset_held");
    @(negedge clk);
    check_all_zero("reset_after_edge");
    if_req = 1'b0; d_req = 1'b0;
    reset = 1'b1;

    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if_req = vt[k].ifr; if_addr = vt[k].ia;
      d_req = vt[k].dr; d_wen = vt[k].dw; d_addr = vt[k].da; d_wdata = vt[k].dd;
      @(negedge clk);
      check($sformatf("v%0d_issue", k), {62'h0, mem_en, busy}, 64'h3);
      check($sformatf("v%0d_addr", k), {32'h0, mem_addr}, {32'h0, vt[k].exp_addr});
      check($sformatf("v%0d_wen", k), {63'h0, mem_wen}, {63'h0, vt[k].exp_wen});
      if (vt[k].exp_wen) check($sformatf("v%0d_wdata", k), {32'h0, mem_wdata}, {32'h0, vt[k].exp_wdata});
      check($sformatf("v%0d_stall", k), {62'h0, if_stall, d_stall}, {62'h0, vt[k].ifr, vt[k].dr});
      @(negedge clk);
      check($sformatf("v%0d_wait", k), {61'h0, mem_en, if_ack, d_ack}, 64'h0);
      @(negedge clk);
      check($sformatf("v%0d_ack", k), {62'h0, if_ack, d_ack}, {62'h0, ~vt[k].exp_d, vt[k].exp_d});
      if (vt[k].exp_d) begin
        check($sformatf("v%0d_if_rdata_zero", k), {32'h0, if_rdata}, 64'h0);
        if (!vt[k].exp_wen) check($sformatf("v%0d_d_rdata", k), {32'h0, d_rdata}, {32'h0, memf(vt[k].exp_addr)});
      end else begin
        check($sformatf("v%0d_d_rdata_zero", k), {32'h0, d_rdata}, 64'h0);
        check($sformatf("v%0d_if_rdata", k), {32'h0, if_rdata}, {32'h0, memf(vt[k].exp_addr)});
      end
      if_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_idle", k), {61'h0, busy, if_ack, d_ack}, 64'h0);
    end

    // Simultaneous requests: data first, fetch follows four cycles later.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h100;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 3) begin
        check("both_d_ack", {62'h0, d_ack, if_ack}, 64'h2);
        check("both_d_rdata", {32'h0, d_rdata}, {32'h0, memf(32'h100)});
        check("both_stalls_c3", {62'h0, d_stall, if_stall}, 64'h1);
        d_req = 1'b0;
      end else if (c == 5) begin
        check("both_if_issue", {31'h0, mem_en, mem_addr}, {31'h0, 1'b1, 32'h10});
      end else if (c == 7) begin
        check("both_if_ack", {62'h0, if_ack, d_ack}, 64'h2);
        check("both_if_rdata", {32'h0, if_rdata}, {32'h0, memf(32'h10)});
        if_req = 1'b0;
      end else if (c == 4) begin
        check("both_if_stall_c4", {63'h0, if_stall}, 64'h1);
      end
    end

    // Starvation: both held; four data grants, then fetch, then data.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h300;
    for (int g = 0; g < 6; g++) begin
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        @(negedge clk);
        if (if_ack | d_ack) got = 1'b1;
      end
      if (!got) begin
        check($sformatf("starve_timeout%0d", g), 64'h0, 64'h1);
        break;
      end
      check($sformatf("starve_grant%0d", g), {63'h0, d_ack}, {63'h0, exp_seq[g]});
      if (g == 4) check("starve_cnt_cleared", {60'h0, dut.r_starve_cnt}, 64'h0);
    end
    if_req = 1'b0; d_req = 1'b0;

    // Reset asserted mid-WAIT abandons the access without an ack.
    @(negedge clk);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    @(negedge clk);
    check("rst_wait_busy", {62'h0, busy, mem_en}, 64'h2);
    #2 reset = 1'b0;
    #1 check_all_zero("rst_async");
    @(negedge clk);
    check_all_zero("rst_no_ack");
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_fresh_noack", {63'h0, if_ack}, 64'h0);
    end
    @(negedge clk);
    check("rst_fresh_ack", {63'h0, if_ack}, 64'h1);
    check("rst_fresh_rdata", {32'h0, if_rdata}, {32'h0, memf(32'h40)});
    if_req = 1'b0;

    // Latency-1 instance: back-to-back fetches every three cycles.
    @(negedge clk);
    if1_req = 1'b1; if1_addr = 32'h500;
    acks1 = 0; last1 = 0; viol1 = 0; prev_en = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      if (mem1_en && prev_en) viol1++;
      prev_en = mem1_en;
      if (if1_ack) begin
        if (acks1 > 0) check($sformatf("lat1_period%0d", acks1), t - last1, 64'd3);
        check($sformatf("lat1_rdata%0d", acks1), {32'h0, if1_rdata}, {32'h0, memf(32'h500)});
        last1 = t;
        acks1++;
      end
    end
    if1_req = 1'b0;
    check("lat1_ack_count", acks1, 64'd4);
    check("lat1_mem_en_gap", viol1, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory of the pipelined processor between two requesters: the fetch stage (instruction port) and the memory stage (data port).
- Serialises accesses to a fixed-latency memory and returns responses to the requester that issued them.
- Drives per-port stall signals into the pipeline hazard logic.
- Sits between the pipeline stages and the memory module.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
MEM_LATENCY, 2, cycles from mem_en to valid mem_rdata; legal range 1..15
STARVE_LIMIT, 4, consecutive data grants while fetch waits before fetch is forced; legal range 1..15

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
if_req  input  1  fetch request, held until if_ack
if_addr  input  ADDR_WIDTH  fetch address
if_ack  output  1  one-cycle response pulse to fetch
if_rdata  output  DATA_WIDTH  fetch read data, valid when if_ack
if_stall  output  1  if_req & ~if_ack
d_req  input  1  data request, held until d_ack
d_wen  input  1  1 = store, 0 = load
d_addr  input  ADDR_WIDTH  data address
d_wdata  input  DATA_WIDTH  store data
d_ack  output  1  one-cycle response pulse to data port
d_rdata  output  DATA_WIDTH  load data, valid when d_ack
d_stall  output  1  d_req & ~d_ack
mem_en  output  1  memory access strobe, one cycle per access
mem_wen  output  1  memory write enable, qualified by mem_en
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en
busy  output  1  high in every state except IDLE

Behaviour:
- Reset state:
  - reset low asynchronously forces IDLE, clears the wait counter, the starvation counter and the grant register.
  - All outputs are 0 while reset is low, including if_rdata and d_rdata.
  - An in-flight access is abandoned with no ack; the memory result is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - At a rising edge with any request high, latch the grant and the winning port's address, wen and wdata, then go to ISSUE.
  - With no request, stay in IDLE.
- Arbitration:
  - The data port wins by default.
  - The instruction port wins if d_req is low, or if starve_cnt == STARVE_LIMIT and if_req is high.
- Starvation counter starve_cnt:
  - Increments on a data grant while if_req is high.
  - Clears on any fetch grant, and on a data grant while if_req is low.
  - Saturates at STARVE_LIMIT.
- ISSUE:
  - Lasts exactly 1 cycle.
  - mem_en=1, and mem_wen/mem_addr/mem_wdata come from the latched values.
  - Next state is WAIT with counter=MEM_LATENCY-1; if MEM_LATENCY==1, next state is RESP.
- WAIT:
  - mem_en=0, counter decrements each cycle, go to RESP when counter==1.
  - The RESP cycle is exactly MEM_LATENCY cycles after the ISSUE cycle.
- RESP:
  - Lasts 1 cycle.
  - Granted port gets ack=1 and rdata=mem_rdata; for stores, rdata is driven but meaningless.
  - Non-granted rdata is 0. Next state is IDLE unconditionally.
- Access timing:
  - Requests are sampled only in IDLE, so a request must be held through its ack.
  - After ack, the requester may change req at that edge; the next IDLE cycle samples the new value.
  - An access costs MEM_LATENCY+2 cycles including IDLE.
- Latching:
  - mem_addr/mem_wen/mem_wdata hold their latched values from ISSUE until the next grant.
  - Requester inputs changing outside IDLE have no effect.
- Stall outputs:
  - if_stall and d_stall are combinational.
  - Both are low during reset.
- Request dropped before ack: protocol violation; the arbiter still completes the access and pulses ack.

Test Plan:
- MEM_LATENCY=2, if_req=1 with if_addr=0x00000010 in IDLE → mem_en at cycle 1 with mem_addr=0x10; if_ack and if_rdata=mem_rdata at cycle 3; if_stall=1 during cycles 0–2.
- if_req and d_req (load, 0x100) raised in the same IDLE cycle → data served first (d_ack at cycle 3); fetch issued next (if_ack at cycle 7); d_stall falls before if_stall.
- Store d_wen=1, d_addr=0x200, d_wdata=0xDEADBEEF → one mem_en cycle with mem_wen=1 and correct address/data; d_ack MEM_LATENCY cycles later; no fetch ack.
- Starvation, STARVE_LIMIT=4: d_req held high and re-asserted after each ack, if_req held high → exactly 4 data grants, then 1 fetch grant, then data again; starve_cnt returns to 0.
- Reset pulse low during WAIT → all outputs 0 immediately without waiting for clk; no ack follows; after release with if_req high, a fresh access completes normally.
- MEM_LATENCY=1 build: back-to-back fetches → acks every 3 cycles; mem_en never high on consecutive cycles.
